// File: rtl/sys_arr_pkg.sv
// Shared types for the systolic-array output path: bank life-cycle states,
// writeback read FSM states and the bank count of the ping-pong tile buffer.
package sys_arr_pkg;

  localparam int NUM_BANKS = 2;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_t;

endpackage

// File: rtl/sysarr_output_collector_if.sv
// Writeback stream from the output collector.
// Handshake: a row transfers on every rising clk edge where wb_valid && wb_ready.
// While wb_valid is high and wb_ready low, wb_data/wb_row/wb_last are held
// stable and wb_valid stays high until the transfer happens.
interface sysarr_output_collector_if #(
  parameter int DW = 16,
  parameter int N  = 4
);
  logic                   wb_valid;
  logic                   wb_ready;
  logic [DW*N-1:0]        wb_data;
  logic [$clog2(N)-1:0]   wb_row;
  logic                   wb_last;

  modport master (output wb_valid, output wb_data, output wb_row, output wb_last, input wb_ready);
  modport slave  (input wb_valid, input wb_data, input wb_row, input wb_last, output wb_ready);
endinterface

// File: rtl/sysarr_out_bank.sv
// One tile bank: N rows of DW*N bits plus a mask of rows received so far.
// clr and wr_en may coincide: the mask restarts with only the new row.
module sysarr_out_bank #(
  parameter int DW = 16,
  parameter int N  = 4
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 wr_en,
  input  logic [$clog2(N)-1:0] wr_row,
  input  logic [DW*N-1:0]      wr_data,
  input  logic [$clog2(N)-1:0] rd_row,
  output logic [DW*N-1:0]      rd_data,
  output logic [N-1:0]         mask,
  input  logic                 clr
);

  logic [DW*N-1:0] rows_q [N];
  logic [N-1:0]    mask_q;
  logic [N-1:0]    mask_d;
  logic [N-1:0]    row_bit;

  // Next mask: optional clear, then set the bit of the row being written.
  always_comb begin
    row_bit         = '0;
    row_bit[wr_row] = 1'b1;
    mask_d          = (clr ? '0 : mask_q) | (wr_en ? row_bit : '0);
  end

  // Mask register; reset discards any partially received tile.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) mask_q <= '0;
    else       mask_q <= mask_d;
  end

  // Row storage; contents are only meaningful where the mask bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) rows_q[wr_row] <= wr_data;
  end

  assign rd_data = rows_q[rd_row];
  assign mask    = mask_q;

endmodule

// File: rtl/sysarr_output_collector.sv
// Systolic-array output collector: gathers result rows (any order) into a
// two-bank tile buffer and streams each complete tile to writeback in row order.
// Optional build macro SYSARR_OUT_RELU_EN: negative lanes are zeroed on write.
module sysarr_output_collector
  import sys_arr_pkg::*;
#(
  parameter int DW = 16,
  parameter int N  = 4
) (
  input  logic                      clk,
  input  logic                      nRST,
  input  logic                      out_en,
  input  logic [$clog2(N)-1:0]      row_out,
  input  logic [DW*N-1:0]           array_output,
  input  logic                      drained,
  output logic                      space_avail,
  sysarr_output_collector_if.master wb,
  output logic                      tile_done,
  output logic [15:0]               tile_cnt,
  output logic                      err_overflow,
  output logic                      err_dup,
  output logic                      err_partial,
  input  logic                      err_clr,
  output rd_state_t                 dbg_rd_state
);

  localparam int RW = $clog2(N);

  bank_state_t       bank_state_q [NUM_BANKS];
  bank_state_t       bank_state_d [NUM_BANKS];
  logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  rd_state_t         rd_state_q, rd_state_d;
  logic [RW-1:0]     rd_row_q, rd_row_d;
  logic              wb_valid_q, wb_valid_d;
  logic              tile_done_q, drained_q;
  logic [15:0]       tile_cnt_q;
  logic              err_ovf_q, err_dup_q, err_part_q;

  logic [DW*N-1:0]   bank_rd_data [NUM_BANKS];
  logic [N-1:0]      bank_mask    [NUM_BANKS];
  logic              bank_wr_en   [NUM_BANKS];
  logic              bank_clr     [NUM_BANKS];

  logic              hs, hs_last, freed, accept, mask_done, dup_set, ovf_set, part_set;
  logic [N-1:0]      row_bit, new_mask;
  logic [DW*N-1:0]   wr_data;
  logic              any_filling, any_space;

  // Write-side decode: acceptance, mask completion and error conditions.
  always_comb begin
    hs        = wb_valid_q && wb.wb_ready;
    hs_last   = hs && (rd_row_q == RW'(N-1));
    // The final handshake frees the bank the writer is waiting on.
    freed     = hs_last && (rd_ptr_q == wr_ptr_q);
    accept    = out_en && (bank_state_q[wr_ptr_q] == EMPTY ||
                           bank_state_q[wr_ptr_q] == FILLING || freed);
    row_bit          = '0;
    row_bit[row_out] = 1'b1;
    new_mask  = (freed ? '0 : bank_mask[wr_ptr_q]) | row_bit;
    mask_done = &new_mask;
    dup_set   = accept && !freed && bank_mask[wr_ptr_q][row_out];
    ovf_set   = out_en && !accept;
  end

  // Lane conditioning before storage.
  always_comb begin
    wr_data = array_output;
`ifdef SYSARR_OUT_RELU_EN
    for (int l = 0; l < N; l++) begin
      if (array_output[l*DW + DW-1]) wr_data[l*DW +: DW] = '0;
    end
`endif
  end

  // Space and partial-tile detection across banks.
  always_comb begin
    any_filling = 1'b0;
    any_space   = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_state_q[b] == FILLING) any_filling = 1'b1;
      if (bank_state_q[b] == EMPTY || bank_state_q[b] == FILLING) any_space = 1'b1;
    end
    part_set = drained && !drained_q && any_filling;
  end

  // Next state: read FSM first, then the write side (which wins on a freed bank).
  always_comb begin
    bank_state_d = bank_state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rd_state_d   = rd_state_q;
    rd_row_d     = rd_row_q;
    wb_valid_d   = wb_valid_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (bank_state_q[rd_ptr_q] == FULL) begin
          bank_state_d[rd_ptr_q] = DRAINING;
          rd_row_d               = '0;
          wb_valid_d             = 1'b1;
          rd_state_d             = RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (hs_last) begin
          bank_state_d[rd_ptr_q] = EMPTY;
          rd_ptr_d               = ~rd_ptr_q;
          rd_row_d               = '0;
          // Claim the other bank immediately if it is already full.
          if (bank_state_q[~rd_ptr_q] == FULL) begin
            bank_state_d[~rd_ptr_q] = DRAINING;
            wb_valid_d              = 1'b1;
          end else begin
            wb_valid_d = 1'b0;
            rd_state_d = RD_IDLE;
          end
        end else if (hs) begin
          rd_row_d = rd_row_q + RW'(1);
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
    if (accept) begin
      bank_state_d[wr_ptr_q] = mask_done ? FULL : FILLING;
      if (mask_done) wr_ptr_d = ~wr_ptr_q;
    end
  end

  // State, pointers, counters and sticky errors (a new error beats err_clr).
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int b = 0; b < NUM_BANKS; b++) bank_state_q[b] <= EMPTY;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      rd_state_q  <= RD_IDLE;
      rd_row_q    <= '0;
      wb_valid_q  <= 1'b0;
      tile_done_q <= 1'b0;
      tile_cnt_q  <= '0;
      drained_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_dup_q   <= 1'b0;
      err_part_q  <= 1'b0;
    end else begin
      bank_state_q <= bank_state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_state_q   <= rd_state_d;
      rd_row_q     <= rd_row_d;
      wb_valid_q   <= wb_valid_d;
      tile_done_q  <= hs_last;
      if (hs_last) tile_cnt_q <= tile_cnt_q + 16'd1;
      drained_q    <= drained;
      err_ovf_q    <= ovf_set  || (err_ovf_q  && !err_clr);
      err_dup_q    <= dup_set  || (err_dup_q  && !err_clr);
      err_part_q   <= part_set || (err_part_q && !err_clr);
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_wr_en[b] = accept  && (wr_ptr_q == 1'(b));
    assign bank_clr[b]   = hs_last && (rd_ptr_q == 1'(b));
    sysarr_out_bank #(.DW(DW), .N(N)) u_bank (
      .clk     (clk),
      .nRST    (nRST),
      .wr_en   (bank_wr_en[b]),
      .wr_row  (row_out),
      .wr_data (wr_data),
      .rd_row  (rd_row_q),
      .rd_data (bank_rd_data[b]),
      .mask    (bank_mask[b]),
      .clr     (bank_clr[b])
    );
  end

  assign wb.wb_valid   = wb_valid_q;
  assign wb.wb_row     = rd_row_q;
  assign wb.wb_last    = (rd_row_q == RW'(N-1));
  assign wb.wb_data    = wb_valid_q ? bank_rd_data[rd_ptr_q] : '0;
  assign space_avail   = any_space;
  assign tile_done     = tile_done_q;
  assign tile_cnt      = tile_cnt_q;
  assign err_overflow  = err_ovf_q;
  assign err_dup       = err_dup_q;
  assign err_partial   = err_part_q;
  assign dbg_rd_state  = rd_state_q;

endmodule

// File: tb/tb_sysarr_output_collector.sv
// Bench for sysarr_output_collector (N=4, DW=16): table-driven in-order tile,
// hand sequences for reorder, backpressure, overrun, dup, partial, reset,
// and a scoreboard fed by a small tile-buffer model.
module tb_sysarr_output_collector;
  import sys_arr_pkg::*;

  localparam int W = 1 + 2 + 64;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        out_en = 1'b0;
  logic [1:0]  row_out = '0;
  logic [63:0] array_output = '0;
  logic        drained = 1'b0;
  logic        err_clr = 1'b0;
  logic        space_avail, tile_done, err_overflow, err_dup, err_partial;
  logic [15:0] tile_cnt;
  rd_state_t   dbg_rd_state;

  sysarr_output_collector_if #(.DW(16), .N(4)) wb_if ();

  sysarr_output_collector #(.DW(16), .N(4)) dut (
    .clk          (clk),
    .nRST         (nRST),
    .out_en       (out_en),
    .row_out      (row_out),
    .array_output (array_output),
    .drained      (drained),
    .space_avail  (space_avail),
    .wb           (wb_if),
    .tile_done    (tile_done),
    .tile_cnt     (tile_cnt),
    .err_overflow (err_overflow),
    .err_dup      (err_dup),
    .err_partial  (err_partial),
    .err_clr      (err_clr),
    .dbg_rd_state (dbg_rd_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // scoreboard state and tile-buffer model
  logic [W-1:0] exp_q[$];
  logic [63:0]  m_tile [4];
  logic [3:0]   m_mask = '0;
  int           m_pending = 0;
  int           m_tiles = 0;
  logic         m_err_ovf = 1'b0;
  logic         m_err_dup = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lane4(input logic [15:0] v);
    return {v, v, v, v};
  endfunction

  function automatic logic [63:0] model_store(input logic [63:0] d);
    logic [63:0] r;
    r = d;
`ifdef SYSARR_OUT_RELU_EN
    for (int l = 0; l < 4; l++) if (r[l*16 + 15]) r[l*16 +: 16] = 16'h0000;
`endif
    return r;
  endfunction

  task automatic model_row(input int r, input logic [63:0] d);
    if (m_pending >= 2) begin
      m_err_ovf = 1'b1;
    end else begin
      if (m_mask[r]) m_err_dup = 1'b1;
      m_tile[r] = model_store(d);
      m_mask[r] = 1'b1;
      if (&m_mask) begin
        for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), 2'(k), m_tile[k]});
        m_pending++;
        m_mask = '0;
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_mask = '0; m_pending = 0; m_tiles = 0;
    m_err_ovf = 1'b0; m_err_dup = 1'b0;
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input int r, input logic [63:0] d);
    out_en = 1'b1; row_out = 2'(r); array_output = d;
    model_row(r, d);
    step();
    out_en = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || wb_if.wb_valid) && n < 200) begin
      step();
      n++;
    end
    total++;
    if (exp_q.size() != 0 || wb_if.wb_valid) begin
      bad++;
      $display("FAIL %s drain timeout: left=%0d expected 0", tag, exp_q.size());
    end
  endtask

  // scoreboard monitor: pops on handshakes, checks hold stability
  logic        prev_hold = 1'b0;
  logic [63:0] prev_data;
  logic [1:0]  prev_row;
  always @(negedge clk) begin
    if (!nRST) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && wb_if.wb_valid) begin
        check("hold_data", wb_if.wb_data, prev_data);
        check("hold_row", 64'(wb_if.wb_row), 64'(prev_row));
      end
      if (wb_if.wb_valid && wb_if.wb_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_extra: got row %0d expected no transfer", wb_if.wb_row);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("sb_data", wb_if.wb_data, e[63:0]);
          check("sb_row", 64'(wb_if.wb_row), 64'(e[65:64]));
          check("sb_last", 64'(wb_if.wb_last), 64'(e[66]));
          if (e[66]) begin
            m_pending--;
            m_tiles++;
          end
        end
      end
      prev_hold = wb_if.wb_valid && !wb_if.wb_ready;
      prev_data = wb_if.wb_data;
      prev_row  = wb_if.wb_row;
    end
  end

  typedef struct {
    logic        en;
    logic [1:0]  row;
    logic [63:0] data;
    logic        ready;
    logic        e_valid;
    logic [1:0]  e_row;
    logic        e_last;
    logic        e_done;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt [10];

  initial begin
    int n;
    vt[0] = '{1'b1, 2'd0, lane4(16'h0001), 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0};
    vt[1] = '{1'b1, 2'd1, lane4(16'h0002), 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0};
    vt[2] = '{1'b1, 2'd2, lane4(16'h0003), 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0};
    vt[3] = '{1'b1, 2'd3, lane4(16'h0004), 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0};
    vt[4] = '{1'b0, 2'd0, 64'd0,           1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 16'd0};
    vt[5] = '{1'b0, 2'd0, 64'd0,           1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 16'd0};
    vt[6] = '{1'b0, 2'd0, 64'd0,           1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 16'd0};
    vt[7] = '{1'b0, 2'd0, 64'd0,           1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 16'd0};
    vt[8] = '{1'b0, 2'd0, 64'd0,           1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 16'd1};
    vt[9] = '{1'b0, 2'd0, 64'd0,           1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'd1};

    wb_if.wb_ready = 1'b0;
    repeat (3) step();
    nRST = 1'b1;
    step();

    // reset state
    check("rst_valid", 64'(wb_if.wb_valid), 64'd0);
    check("rst_space", 64'(space_avail), 64'd1);
    check("rst_cnt", 64'(tile_cnt), 64'd0);
    check("rst_errs", 64'({err_overflow, err_dup, err_partial, tile_done}), 64'd0);
    check("rst_fsm", 64'(dbg_rd_state), 64'(RD_IDLE));

    // in-order tile from the vector table
    for (int i = 0; i < 10; i++) begin
      out_en = vt[i].en; row_out = vt[i].row; array_output = vt[i].data;
      wb_if.wb_ready = vt[i].ready;
      if (vt[i].en) model_row(int'(vt[i].row), vt[i].data);
      step();
      out_en = 1'b0;
      check($sformatf("vec%0d_valid", i), 64'(wb_if.wb_valid), 64'(vt[i].e_valid));
      check($sformatf("vec%0d_row", i), 64'(wb_if.wb_row), 64'(vt[i].e_row));
      check($sformatf("vec%0d_last", i), 64'(wb_if.wb_last), 64'(vt[i].e_last));
      check($sformatf("vec%0d_done", i), 64'(tile_done), 64'(vt[i].e_done));
      check($sformatf("vec%0d_cnt", i), 64'(tile_cnt), 64'(vt[i].e_cnt));
    end

    // out-of-order fill with a 3-cycle backpressure window mid-tile
    send_row(2, {16'h1002, 16'h2002, 16'h3002, 16'h4002});
    send_row(0, {16'h1000, 16'h2000, 16'h3000, 16'h4000});
    send_row(3, {16'h1003, 16'h2003, 16'h3003, 16'h4003});
    send_row(1, {16'h1001, 16'h2001, 16'h3001, 16'h4001});
    repeat (3) step();
    wb_if.wb_ready = 1'b0;
    repeat (3) step();
    wb_if.wb_ready = 1'b1;
    wait_drain("ooo");
    check("ooo_cnt", 64'(tile_cnt), 64'(m_tiles));

    // overrun: two full tiles with writeback stalled, then one more row
    wb_if.wb_ready = 1'b0;
    for (int r = 0; r < 4; r++) send_row(r, lane4(16'h0C00 + 16'(r)));
    for (int r = 0; r < 4; r++) send_row(r, lane4(16'h0D00 + 16'(r)));
    check("ovr_space", 64'(space_avail), 64'd0);
    check("ovr_flag_pre", 64'(err_overflow), 64'd0);
    send_row(0, lane4(16'h0E00));
    check("ovr_flag", 64'(err_overflow), 64'(m_err_ovf));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("ovr_clr", 64'(err_overflow), 64'd0);
    wb_if.wb_ready = 1'b1;
    wait_drain("ovr");
    check("ovr_cnt", 64'(tile_cnt), 64'(m_tiles));
    check("ovr_space_back", 64'(space_avail), 64'd1);

    // duplicate row: second write wins and err_dup latches
    send_row(0, lane4(16'h0100));
    send_row(1, lane4(16'h0101));
    check("dup_pre", 64'(err_dup), 64'd0);
    send_row(1, lane4(16'hBEEF));
    check("dup_flag", 64'(err_dup), 64'(m_err_dup));
    send_row(2, lane4(16'h0102));
    send_row(3, lane4(16'h0103));
    wait_drain("dup");
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("dup_clr", 64'(err_dup), 64'd0);

    // partial tile at drained rise, with err_clr in the same cycle
    send_row(0, lane4(16'h0200));
    send_row(1, lane4(16'h0201));
    send_row(2, lane4(16'h0202));
    drained = 1'b1; err_clr = 1'b1;
    step();
    drained = 1'b0; err_clr = 1'b0;
    check("part_flag", 64'(err_partial), 64'd1);
    step();
    check("part_hold_valid", 64'(wb_if.wb_valid), 64'd0);
    check("part_space", 64'(space_avail), 64'd1);
    send_row(3, lane4(16'h0203));
    wait_drain("part");
    check("part_cnt", 64'(tile_cnt), 64'(m_tiles));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("part_clr", 64'(err_partial), 64'd0);

`ifdef SYSARR_OUT_RELU_EN
    // negative lanes zeroed on write
    for (int r = 0; r < 4; r++) send_row(r, {16'hBC00, 16'h3C00, 16'hBC00, 16'h3C00});
    wait_drain("relu");
`endif

    // reset in the middle of streaming row 2
    for (int r = 0; r < 4; r++) send_row(r, lane4(16'h0300 + 16'(r)));
    n = 0;
    while (!(wb_if.wb_valid && wb_if.wb_row == 2'd2) && n < 20) begin
      step();
      n++;
    end
    check("mid_found", 64'(wb_if.wb_valid && wb_if.wb_row == 2'd2), 64'd1);
    nRST = 1'b0;
    #1;
    check("mid_valid", 64'(wb_if.wb_valid), 64'd0);
    check("mid_cnt", 64'(tile_cnt), 64'd0);
    check("mid_space", 64'(space_avail), 64'd1);
    model_reset();
    repeat (2) step();
    nRST = 1'b1;
    repeat (3) step();
    check("post_rst_valid", 64'(wb_if.wb_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
